spi_disp_queue: RTL and testbench

//  Buffered command/data feeder that sits directly upstream of the SPI display peripheral and masters its control bus.
//  The CPU pushes bytes tagged as command (dc=0) or data (dc=1) into a FIFO.
//  The block sequences chip-select, DC and byte transfers on the downstream bus without CPU involvement.

---
 rtl/spi_disp_pkg.sv | 19 +
 rtl/spi_byte_fifo.sv | 52 +++++
 rtl/spi_disp_queue.sv | 157 +++++++++++++++
 tb/tb_spi_disp_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_disp_pkg.sv
// spi_disp_pkg: shared offsets, FSM states and FIFO entry type for the SPI display queue.
//   DQ_*   : CPU-side register offsets
//   SPI_*  : downstream SPI peripheral register offsets
//   state_t: sequencer states
//   entry_t: one queued {dc, byte} item
package spi_disp_pkg;
    localparam logic [7:0] DQ_CMD   = 8'h00;
    localparam logic [7:0] DQ_DAT   = 8'h04;
    localparam logic [7:0] DQ_STAT  = 8'h08;
    localparam logic [7:0] DQ_CTRL  = 8'h0C;
    localparam logic [7:0] SPI_CS   = 8'h04;
    localparam logic [7:0] SPI_BYTE = 8'h08;
    localparam logic [7:0] SPI_DC   = 8'h10;
    typedef enum logic [2:0] {ST_IDLE, ST_CS_LO, ST_DC_CHK, ST_DC_WR, ST_BYTE, ST_CS_HI} state_t;
    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } entry_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous {dc,byte} FIFO with the head entry visible combinationally.
//   push_i/pop_i : enqueue/dequeue requests (ignored when full/empty; push at full is
//                  accepted if a pop happens in the same cycle)
//   flush_i      : drop all entries
//   head_o       : oldest entry, valid while !empty_o
//   level_o      : entry count, 0..DEPTH
module spi_byte_fifo
    import spi_disp_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        din_i,
    output entry_t        head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] level_o
);
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    entry_t        mem_q [DEPTH];
    logic          pop_ok, push_ok;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign level_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (!resetn || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/spi_disp_queue.sv
// spi_disp_queue: buffered command/data feeder mastering the SPI display peripheral bus.
//   s_*       : CPU register port (push cmd/data, STAT, CTRL), held request / 1-cycle s_done_o
//   m_*       : downstream register-write master, request held until m_done_i
//   irq_empty_o: high while the FIFO is empty and the sequencer is idle
module spi_disp_queue
    import spi_disp_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter bit AUTO_CS_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_wr_i,
    input  logic        s_rd_i,
    input  logic [7:0]  s_addr_i,
    input  logic [31:0] s_wdat_i,
    output logic [31:0] s_rdat_o,
    output logic        s_done_o,
    output logic        m_wr_o,
    output logic [7:0]  m_addr_o,
    output logic [31:0] m_wdat_o,
    input  logic        m_done_i,
    output logic        irq_empty_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q, end_st;
    logic          s_done_q, auto_cs_q, flush_q, ovf_q;
    logic [31:0]   s_rdat_q, s_rdat_d, stat, rd_val;
    logic          m_wr_q, cur_dc_q, dc_valid_q;
    logic [7:0]    m_addr_q;
    logic [31:0]   m_wdat_q;
    logic          req, wr_req, rd_req, ctrl_wr, push_req, stall, do_push, do_pop;
    logic          s_done_d, busy, full, empty, dc_chg, nxt_empty;
    logic [LW-1:0] level, lvl_nxt;
    entry_t        head, din;
    logic          unused_wdat;

    spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push_i (do_push),
        .pop_i  (do_pop),
        .flush_i(flush_q),
        .din_i  (din),
        .head_o (head),
        .full_o (full),
        .empty_o(empty),
        .level_o(level)
    );

    // A request is only sampled outside the s_done cycle.
    assign req      = !s_done_q && (s_wr_i || s_rd_i);
    assign wr_req   = req && s_wr_i;
    assign rd_req   = req && s_rd_i && !s_wr_i;
    assign ctrl_wr  = wr_req && s_addr_i == DQ_CTRL;
    assign push_req = wr_req && (s_addr_i == DQ_CMD || s_addr_i == DQ_DAT);
    assign do_pop   = state_q == ST_BYTE && m_wr_q && m_done_i && !empty;
    // A push at full waits, unless the in-flight byte retires this cycle and frees a slot.
    assign stall    = push_req && full && !do_pop;
    assign do_push  = push_req && !stall;
    assign din      = {s_addr_i == DQ_DAT, s_wdat_i[7:0]};
    assign busy     = state_q != ST_IDLE;
    assign stat     = {16'(level), 12'b0, busy, ovf_q, full, empty};
    assign rd_val   = s_addr_i == DQ_STAT ? stat : s_addr_i == DQ_CTRL ? {31'b0, auto_cs_q} : '0;
    assign s_done_d = req && !stall;
    assign s_rdat_d = rd_req ? rd_val : '0;
    assign unused_wdat = ^s_wdat_i[31:8];

    // Occupancy after this cycle's push/pop; a pending flush empties the FIFO regardless.
    assign lvl_nxt   = level + LW'(do_push) - LW'(do_pop);
    assign nxt_empty = flush_q || lvl_nxt == '0;
    assign dc_chg    = !dc_valid_q || head.dc != cur_dc_q;
    assign end_st    = auto_cs_q ? ST_CS_HI : ST_IDLE;

    assign s_done_o    = s_done_q;
    assign s_rdat_o    = s_rdat_q;
    assign m_wr_o      = m_wr_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdat_o    = m_wdat_q;
    assign irq_empty_o = empty && !busy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_done_q  <= 1'b0;
            s_rdat_q  <= '0;
            auto_cs_q <= AUTO_CS_DEFAULT;
            flush_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s_done_q <= s_done_d;
            s_rdat_q <= s_rdat_d;
            flush_q  <= ctrl_wr && s_wdat_i[1];
            ovf_q    <= stall || (ovf_q && !(ctrl_wr && s_wdat_i[2]));
            if (ctrl_wr) auto_cs_q <= s_wdat_i[0];
        end
    end

    // Write states raise m_wr one cycle after entry (the mandatory idle gap after m_done);
    // DC_CHK already is that gap cycle, so it loads the next request directly.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            m_wr_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdat_q   <= '0;
            cur_dc_q   <= 1'b0;
            dc_valid_q <= 1'b0;
        end else begin
            if (m_wr_q && m_done_i) m_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (!empty) state_q <= auto_cs_q ? ST_CS_LO : ST_DC_CHK;
                ST_CS_LO: begin
                    if (!m_wr_q) begin
                        m_wr_q   <= 1'b1;
                        m_addr_q <= SPI_CS;
                        m_wdat_q <= 32'd0;
                    end else if (m_done_i) state_q <= ST_DC_CHK;
                end
                ST_DC_CHK: begin
                    m_wr_q   <= !empty || auto_cs_q;
                    m_addr_q <= empty ? SPI_CS : dc_chg ? SPI_DC : SPI_BYTE;
                    m_wdat_q <= empty ? 32'd1 : dc_chg ? {31'b0, head.dc} : {24'b0, head.data};
                    state_q  <= empty ? end_st : dc_chg ? ST_DC_WR : ST_BYTE;
                end
                ST_DC_WR: begin
                    if (m_wr_q && m_done_i) begin
                        cur_dc_q   <= m_wdat_q[0];
                        dc_valid_q <= 1'b1;
                        state_q    <= ST_BYTE;
                    end
                end
                ST_BYTE: begin
                    if (!m_wr_q) begin
                        if (empty) state_q <= end_st;
                        else begin
                            m_wr_q   <= 1'b1;
                            m_addr_q <= SPI_BYTE;
                            m_wdat_q <= {24'b0, head.data};
                        end
                    end else if (m_done_i) state_q <= nxt_empty ? end_st : ST_DC_CHK;
                end
                ST_CS_HI: begin
                    if (!m_wr_q) begin
                        m_wr_q   <= 1'b1;
                        m_addr_q <= SPI_CS;
                        m_wdat_q <= 32'd1;
                    end else if (m_done_i) begin
                        dc_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_disp_queue.sv
// tb_spi_disp_queue: scoreboard bench for spi_disp_queue with a downstream responder model.
module tb_spi_disp_queue;
    import spi_disp_pkg::*;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        s_wr = 1'b0, s_rd = 1'b0, m_done = 1'b0;
    logic [7:0]  s_addr = '0;
    logic [31:0] s_wdat = '0;
    logic [31:0] s_rdat, m_wdat;
    logic        s_done, m_wr, irq_empty;
    logic [7:0]  m_addr;

    int          errs = 0, chks = 0, rcnt = 0;
    bit          resp_en = 1'b0;
    logic [39:0] exp_q[$];
    logic        mon_prev = 1'b0, mon_gap = 1'b0;
    logic [39:0] mon_rec = '0;
    logic [31:0] rd;

    spi_disp_queue dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_wr_i     (s_wr),
        .s_rd_i     (s_rd),
        .s_addr_i   (s_addr),
        .s_wdat_i   (s_wdat),
        .s_rdat_o   (s_rdat),
        .s_done_o   (s_done),
        .m_wr_o     (m_wr),
        .m_addr_o   (m_addr),
        .m_wdat_o   (m_wdat),
        .m_done_i   (m_done),
        .irq_empty_o(irq_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_w(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        s_wr = 1'b1; s_addr = a; s_wdat = d;
        while (!s_done && n < 500) begin @(negedge clk); n++; end
        if (!s_done) chk("cpu write timeout", 40'(s_done), 40'd1);
        s_wr = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        s_rd = 1'b1; s_addr = a;
        while (!s_done && n < 500) begin @(negedge clk); n++; end
        if (!s_done) chk("cpu read timeout", 40'(s_done), 40'd1);
        d = s_rdat;
        s_rd = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || !irq_empty) && n < 3000) begin @(negedge clk); n++; end
        chk({nm, " pending writes"}, 40'(exp_q.size()), 40'd0);
        chk({nm, " irq_empty"}, 40'(irq_empty), 40'd1);
    endtask

    task automatic wait_byte(input string nm);
        int n = 0;
        while (!(m_wr && m_addr == SPI_BYTE) && n < 500) begin @(negedge clk); n++; end
        resp_en = 1'b0;
        chk({nm, " reach BYTE"}, {31'b0, m_wr, m_addr}, {31'b0, 1'b1, SPI_BYTE});
    endtask

    // Downstream responder: completes each request after it has been up for two cycles.
    initial forever begin
        @(posedge clk); #1;
        if (!resetn || m_done) begin m_done = 1'b0; rcnt = 0; end
        else if (m_wr && resp_en) begin
            rcnt++;
            if (rcnt >= 2) m_done = 1'b1;
        end
    end

    // Monitor: checks each completed downstream write against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mon_gap) begin chk("m_wr gap after m_done", 40'(m_wr), 40'd0); mon_gap = 1'b0; end
        if (m_wr && !mon_prev) mon_rec = {m_addr, m_wdat};
        if (m_wr && m_done) begin
            chk("m request stable", {m_addr, m_wdat}, mon_rec);
            if (exp_q.size() == 0) begin
                chks++; errs++;
                $display("FAIL unexpected m write: got %h expected none", {m_addr, m_wdat});
            end else chk("m write", {m_addr, m_wdat}, exp_q.pop_front());
            mon_gap = 1'b1;
        end
        mon_prev = m_wr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset m_wr", 40'(m_wr), 40'd0);
        chk("reset m_addr", 40'(m_addr), 40'd0);
        chk("reset s_done", 40'(s_done), 40'd0);
        chk("reset s_rdat", 40'(s_rdat), 40'd0);
        chk("reset irq_empty", 40'(irq_empty), 40'd1);
        resetn = 1'b1;
        cpu_rd(DQ_STAT, rd); chk("reset STAT", 40'(rd), 40'h1);
        cpu_rd(DQ_CTRL, rd); chk("reset CTRL", 40'(rd), 40'h1);
        cpu_rd(8'h20, rd);   chk("unmapped read", 40'(rd), 40'h0);
        cpu_wr(8'h10, 32'hFF);
        cpu_rd(DQ_STAT, rd); chk("unmapped write STAT", 40'(rd), 40'h1);

        // 1: single command with auto chip-select, plus first-request latency
        resp_en = 1'b1;
        expect_w(SPI_CS, 0); expect_w(SPI_DC, 0); expect_w(SPI_BYTE, 32'hAF); expect_w(SPI_CS, 1);
        cpu_wr(DQ_CMD, 32'hAF);
        @(negedge clk); chk("latency +1 m_wr", 40'(m_wr), 40'd0);
        @(negedge clk); chk("latency +2 m_wr", 40'(m_wr), 40'd1);
        drain("t1");

        // 2: cmd then two data bytes: one CS frame, DC written only on change
        resp_en = 1'b0;
        expect_w(SPI_CS, 0); expect_w(SPI_DC, 0); expect_w(SPI_BYTE, 32'h15);
        expect_w(SPI_DC, 1); expect_w(SPI_BYTE, 32'h00); expect_w(SPI_BYTE, 32'h5F); expect_w(SPI_CS, 1);
        cpu_wr(DQ_CMD, 32'h15); cpu_wr(DQ_DAT, 32'h00); cpu_wr(DQ_DAT, 32'h5F);
        resp_en = 1'b1;
        drain("t2");

        // 3: overfill with downstream stalled
        resp_en = 1'b0;
        expect_w(SPI_CS, 0); expect_w(SPI_DC, 0);
        for (int i = 0; i < 17; i++) expect_w(SPI_BYTE, 32'h30 + i);
        expect_w(SPI_CS, 1);
        for (int i = 0; i < 16; i++) cpu_wr(DQ_CMD, 32'h30 + i);
        cpu_rd(DQ_STAT, rd); chk("full STAT", 40'(rd), 40'h0010_000A);
        @(negedge clk);
        s_wr = 1'b1; s_addr = DQ_CMD; s_wdat = 32'h40;
        repeat (6) @(negedge clk);
        chk("stalled push s_done", 40'(s_done), 40'd0);
        resp_en = 1'b1;
        for (int n = 0; n < 200 && !s_done; n++) @(negedge clk);
        resp_en = 1'b0;
        chk("stalled push released", 40'(s_done), 40'd1);
        s_wr = 1'b0;
        cpu_rd(DQ_STAT, rd); chk("overflow STAT", 40'(rd), 40'h0010_000E);
        cpu_wr(DQ_CTRL, 32'h5);
        cpu_rd(DQ_STAT, rd); chk("overflow cleared STAT", 40'(rd), 40'h0010_000A);
        resp_en = 1'b1;
        drain("t3");

        // 4: flush with ten queued while a byte is in flight
        resp_en = 1'b0;
        expect_w(SPI_CS, 0); expect_w(SPI_DC, 1); expect_w(SPI_BYTE, 32'h50); expect_w(SPI_CS, 1);
        for (int i = 0; i < 10; i++) cpu_wr(DQ_DAT, 32'h50 + i);
        resp_en = 1'b1;
        wait_byte("t4");
        cpu_wr(DQ_CTRL, 32'h3);
        cpu_rd(DQ_STAT, rd); chk("flushed STAT", 40'(rd), 40'h0000_0009);
        cpu_rd(DQ_CTRL, rd); chk("CTRL after flush", 40'(rd), 40'h1);
        resp_en = 1'b1;
        drain("t4");
        cpu_rd(DQ_STAT, rd); chk("post-flush STAT", 40'(rd), 40'h1);

        // 5: reset in the middle of a byte transfer
        resp_en = 1'b0;
        expect_w(SPI_CS, 0); expect_w(SPI_DC, 0);
        cpu_wr(DQ_CMD, 32'h11); cpu_wr(DQ_CMD, 32'h22);
        resp_en = 1'b1;
        wait_byte("t5");
        chk("t5 pending before reset", 40'(exp_q.size()), 40'd0);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid-reset m_wr", 40'(m_wr), 40'd0);
        chk("mid-reset irq_empty", 40'(irq_empty), 40'd1);
        resetn = 1'b1;
        cpu_rd(DQ_STAT, rd); chk("after reset STAT", 40'(rd), 40'h1);

        // 6: manual chip-select: no CS writes at all
        cpu_wr(DQ_CTRL, 32'h0);
        resp_en = 1'b0;
        expect_w(SPI_DC, 1); expect_w(SPI_BYTE, 32'hA1); expect_w(SPI_BYTE, 32'hA2);
        cpu_wr(DQ_DAT, 32'hA1); cpu_wr(DQ_DAT, 32'hA2);
        resp_en = 1'b1;
        drain("t6");
        cpu_rd(DQ_CTRL, rd); chk("manual CTRL", 40'(rd), 40'h0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
